ternary_code_transmitter: RTL and testbench

- Transmit-side counterpart of the zero-DSP correlator.
- Emits a ternary (−1/0/+1) code as an AXI-Stream sample train of scaled chips, with oversampling, multi-pulse bursts and inter-pulse zero gaps.
- Chips are ordered so that the correlator, loaded with the same coefficient vector, peaks on the last sample of each pulse.
- Uses no DSP slices: each chip maps to +A, −A or 0 through a mux and a saturating negate.

---
 rtl/zero_dsp_pkg.sv | 31 +++
 rtl/ternary_chip_mapper.sv | 34 +++
 rtl/ternary_code_transmitter.sv | 214 +++++++++++++++++++++
 tb/tb_ternary_code_transmitter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/zero_dsp_pkg.sv
// rtl/zero_dsp_pkg.sv - shared coefficient codes, transmitter states and saturating negate
package zero_dsp_pkg;

    localparam logic [1:0] COEF_ZERO = 2'b00;
    localparam logic [1:0] COEF_POS  = 2'b01;
    localparam logic [1:0] COEF_NEG  = 2'b11;
    localparam logic [1:0] COEF_RSVD = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        CHIP,
        GAP,
        DONE
    } tx_state_t;

    // Two's-complement negate of the low 'width' bits of a (width <= 64).
    // The most negative value has no positive twin, so it clamps to the
    // largest positive value instead of wrapping back onto itself.
    function automatic logic [63:0] sat_negate(input logic [63:0] a, input int unsigned width);
        logic [63:0] mask;
        logic [63:0] min_neg;
        mask    = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
        min_neg = 64'd1 << (width - 1);
        if ((a & mask) == min_neg) begin
            sat_negate = min_neg - 64'd1;
        end else begin
            sat_negate = (~a + 64'd1) & mask;
        end
    endfunction

endpackage

// File: rtl/ternary_chip_mapper.sv
// rtl/ternary_chip_mapper.sv - combinational ternary chip to signed sample mapper
//
// Ports:
//   coef      - 2-bit ternary chip code (01=+1, 11=-1, 00/10=0)
//   amplitude - signed chip amplitude A
//   sample    - +A, saturated -A, or 0
module ternary_chip_mapper
    import zero_dsp_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic [1:0]            coef,
    input  logic [DATA_WIDTH-1:0] amplitude,
    output logic [DATA_WIDTH-1:0] sample
);

    logic [63:0]            neg_wide;
    logic [DATA_WIDTH-1:0]  neg_amp;
    logic [63-DATA_WIDTH:0] unused_neg_hi;

    assign neg_wide      = sat_negate(64'(amplitude), DATA_WIDTH);
    assign neg_amp       = neg_wide[DATA_WIDTH-1:0];
    assign unused_neg_hi = neg_wide[63:DATA_WIDTH];

    always_comb begin
        sample = '0;
        case (coef)
            COEF_POS: sample = amplitude;
            COEF_NEG: sample = neg_amp;
            default:  sample = '0;
        endcase
    end

endmodule

// File: rtl/ternary_code_transmitter.sv
// rtl/ternary_code_transmitter.sv - ternary code burst transmitter on an AXI-Stream master
//
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   cfg_*                 - burst configuration, captured when start is accepted in IDLE
//   start, abort          - burst request / burst termination
//   m_axis_t*             - sample stream (tlast on last sample of each pulse)
//   m_axis_tuser          - only with ZD_TX_TUSER_EN: {gap flag, chip index}
//   status_busy/done      - not-IDLE flag, one-cycle normal completion pulse
//   status_pulse_cnt      - pulses completed in the current or last burst (saturating)
// Optional feature macro: ZD_TX_TUSER_EN
module ternary_code_transmitter
    import zero_dsp_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int COEF_WIDTH  = 2,
    parameter int CODE_LENGTH = 64,
    parameter int OSR_WIDTH   = 5,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [CODE_LENGTH*COEF_WIDTH-1:0] cfg_coefficients,
    input  logic [DATA_WIDTH-1:0]             cfg_amplitude,
    input  logic [OSR_WIDTH-1:0]              cfg_osr,
    input  logic [CNT_WIDTH-1:0]              cfg_num_pulses,
    input  logic [CNT_WIDTH-1:0]              cfg_gap,
    input  logic                              start,
    input  logic                              abort,
    output logic [DATA_WIDTH-1:0]             m_axis_tdata,
    output logic                              m_axis_tvalid,
    input  logic                              m_axis_tready,
    output logic                              m_axis_tlast,
`ifdef ZD_TX_TUSER_EN
    output logic [$clog2(CODE_LENGTH):0]      m_axis_tuser,
`endif
    output logic                              status_busy,
    output logic                              status_done,
    output logic [CNT_WIDTH-1:0]              status_pulse_cnt
);

    localparam int             IDX_W     = (CODE_LENGTH > 1) ? $clog2(CODE_LENGTH) : 1;
    localparam logic [IDX_W-1:0] LAST_CHIP = IDX_W'(CODE_LENGTH - 1);

    tx_state_t state, nxt_state;

    logic [CODE_LENGTH*COEF_WIDTH-1:0] coef_q;
    logic [DATA_WIDTH-1:0]             amp_q;
    logic [OSR_WIDTH-1:0]              osr_q;
    logic [CNT_WIDTH-1:0]              num_pulses_q, gap_q;

    // Position of the beat currently held in the output register.
    logic [IDX_W-1:0]     chip_idx, nxt_chip;
    logic [OSR_WIDTH-1:0] osr_cnt, nxt_osr;
    logic [CNT_WIDTH-1:0] gap_cnt, nxt_gap;
    logic [CNT_WIDTH-1:0] pulse_cnt, nxt_pulse_cnt, pulse_cnt_inc;
    logic                 abort_q, nxt_abort;
    logic                 nxt_valid, nxt_last, launch, accept, more_pulses;

    logic [DATA_WIDTH-1:0]             tdata_q, nxt_data, mapped;
    logic                              tvalid_q, tlast_q;
    logic [CODE_LENGTH*COEF_WIDTH-1:0] coef_src;
    logic [DATA_WIDTH-1:0]             amp_src;
    logic [OSR_WIDTH-1:0]              cfg_osr_eff, osr_src;

    assign cfg_osr_eff   = (cfg_osr == '0) ? OSR_WIDTH'(1) : cfg_osr;
    // While IDLE the first beat is built straight from the cfg inputs so it
    // can be registered on the same edge that accepts start.
    assign coef_src      = (state == IDLE) ? cfg_coefficients : coef_q;
    assign amp_src       = (state == IDLE) ? cfg_amplitude : amp_q;
    assign osr_src       = (state == IDLE) ? cfg_osr_eff : osr_q;
    assign accept        = tvalid_q && m_axis_tready;
    assign pulse_cnt_inc = (pulse_cnt == '1) ? pulse_cnt : pulse_cnt + 1'b1;
    assign more_pulses   = ({1'b0, pulse_cnt} + {{CNT_WIDTH{1'b0}}, 1'b1}) < {1'b0, num_pulses_q};

    ternary_chip_mapper #(.DATA_WIDTH(DATA_WIDTH)) u_mapper (
        .coef      (coef_src[2*nxt_chip +: 2]),
        .amplitude (amp_src),
        .sample    (mapped)
    );

    always_comb begin
        nxt_state     = state;
        nxt_chip      = chip_idx;
        nxt_osr       = osr_cnt;
        nxt_gap       = gap_cnt;
        nxt_pulse_cnt = pulse_cnt;
        nxt_abort     = abort_q;
        nxt_valid     = tvalid_q;
        launch        = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    launch        = 1'b1;
                    nxt_pulse_cnt = '0;
                    nxt_abort     = 1'b0;
                    nxt_chip      = LAST_CHIP;
                    nxt_osr       = '0;
                    if (cfg_num_pulses == '0) begin
                        nxt_state = DONE;
                    end else begin
                        nxt_state = CHIP;
                        nxt_valid = 1'b1;
                    end
                end
            end
            CHIP, GAP: begin
                if (abort || abort_q) begin
                    // A beat already presented must complete its handshake.
                    if (tvalid_q && !m_axis_tready) begin
                        nxt_abort = 1'b1;
                    end else begin
                        nxt_state = IDLE;
                        nxt_valid = 1'b0;
                        nxt_abort = 1'b0;
                        if (accept && tlast_q) nxt_pulse_cnt = pulse_cnt_inc;
                    end
                end else if (accept) begin
                    if (state == GAP) begin
                        if (gap_cnt == gap_q - 1'b1) begin
                            nxt_state = CHIP;
                            nxt_chip  = LAST_CHIP;
                            nxt_osr   = '0;
                        end else begin
                            nxt_gap = gap_cnt + 1'b1;
                        end
                    end else if (osr_cnt != osr_q - 1'b1) begin
                        nxt_osr = osr_cnt + 1'b1;
                    end else if (chip_idx != '0) begin
                        nxt_chip = chip_idx - 1'b1;
                        nxt_osr  = '0;
                    end else begin
                        nxt_pulse_cnt = pulse_cnt_inc;
                        if (!more_pulses) begin
                            nxt_state = DONE;
                            nxt_valid = 1'b0;
                        end else if (gap_q != '0) begin
                            nxt_state = GAP;
                            nxt_gap   = '0;
                        end else begin
                            nxt_chip = LAST_CHIP;
                            nxt_osr  = '0;
                        end
                    end
                end
            end
            DONE: nxt_state = IDLE;
            default: nxt_state = IDLE;
        endcase
        nxt_data = (nxt_valid && nxt_state == CHIP) ? mapped : '0;
        nxt_last = nxt_valid && (nxt_state == CHIP) && (nxt_chip == '0)
                   && (nxt_osr == osr_src - 1'b1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            coef_q       <= '0;
            amp_q        <= '0;
            osr_q        <= '0;
            num_pulses_q <= '0;
            gap_q        <= '0;
            chip_idx     <= '0;
            osr_cnt      <= '0;
            gap_cnt      <= '0;
            pulse_cnt    <= '0;
            abort_q      <= 1'b0;
            tdata_q      <= '0;
            tvalid_q     <= 1'b0;
            tlast_q      <= 1'b0;
        end else begin
            state     <= nxt_state;
            chip_idx  <= nxt_chip;
            osr_cnt   <= nxt_osr;
            gap_cnt   <= nxt_gap;
            pulse_cnt <= nxt_pulse_cnt;
            abort_q   <= nxt_abort;
            tdata_q   <= nxt_data;
            tvalid_q  <= nxt_valid;
            tlast_q   <= nxt_last;
            if (launch) begin
                coef_q       <= cfg_coefficients;
                amp_q        <= cfg_amplitude;
                osr_q        <= cfg_osr_eff;
                num_pulses_q <= cfg_num_pulses;
                gap_q        <= cfg_gap;
            end
        end
    end

`ifdef ZD_TX_TUSER_EN
    logic [IDX_W:0] tuser_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tuser_q <= '0;
        end else if (!nxt_valid) begin
            tuser_q <= '0;
        end else if (nxt_state == GAP) begin
            tuser_q <= {1'b1, {IDX_W{1'b0}}};
        end else begin
            tuser_q <= {1'b0, nxt_chip};
        end
    end
    assign m_axis_tuser = tuser_q;
`endif

    assign m_axis_tdata     = tdata_q;
    assign m_axis_tvalid    = tvalid_q;
    assign m_axis_tlast     = tlast_q;
    assign status_busy      = (state != IDLE);
    assign status_done      = (state == DONE);
    assign status_pulse_cnt = pulse_cnt;

endmodule

// File: tb/tb_ternary_code_transmitter.sv
// tb/tb_ternary_code_transmitter.sv - directed self-checking bench for ternary_code_transmitter
module tb_ternary_code_transmitter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  cfg_coefficients = '0;
    logic [15:0] cfg_amplitude = '0;
    logic [4:0]  cfg_osr = '0;
    logic [15:0] cfg_num_pulses = '0;
    logic [15:0] cfg_gap = '0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
    logic        m_axis_tlast;
    logic        status_busy;
    logic        status_done;
    logic [15:0] status_pulse_cnt;

    int vectors = 0;
    int errors  = 0;
    int done_seen;
    int got_data[$];
    int got_last[$];
    int exp_data[$];
    int exp_last[$];

    ternary_code_transmitter #(
        .DATA_WIDTH(16), .COEF_WIDTH(2), .CODE_LENGTH(4), .OSR_WIDTH(5), .CNT_WIDTH(16)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_coefficients(cfg_coefficients), .cfg_amplitude(cfg_amplitude),
        .cfg_osr(cfg_osr), .cfg_num_pulses(cfg_num_pulses), .cfg_gap(cfg_gap),
        .start(start), .abort(abort),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
        .status_busy(status_busy), .status_done(status_done),
        .status_pulse_cnt(status_pulse_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int observed, input int expected);
        vectors++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic set_cfg(input logic [7:0] c, input int a, input int o, input int p, input int g);
        cfg_coefficients = c;
        cfg_amplitude    = a[15:0];
        cfg_osr          = o[4:0];
        cfg_num_pulses   = p[15:0];
        cfg_gap          = g[15:0];
    endtask

    // Reference stream for a burst: chips 3..0, each repeated osr times, gaps between pulses.
    task automatic build_exp(input logic [7:0] c, input int a, input int o, input int p, input int g);
        int osr_eff;
        int v;
        logic [1:0] code;
        exp_data.delete();
        exp_last.delete();
        osr_eff = (o == 0) ? 1 : o;
        for (int pp = 0; pp < p; pp++) begin
            for (int ch = 3; ch >= 0; ch--) begin
                code = c[2*ch +: 2];
                if (code == 2'b01)      v = a;
                else if (code == 2'b11) v = (a == -32768) ? 32767 : -a;
                else                    v = 0;
                for (int k = 0; k < osr_eff; k++) begin
                    exp_data.push_back(v);
                    exp_last.push_back((ch == 0 && k == osr_eff - 1) ? 1 : 0);
                end
            end
            if (pp < p - 1) begin
                for (int k = 0; k < g; k++) begin
                    exp_data.push_back(0);
                    exp_last.push_back(0);
                end
            end
        end
    endtask

    // Pulses start, scrambles cfg afterwards, re-pulses start mid-burst (must be ignored),
    // and collects accepted beats until the DUT returns to IDLE.
    task automatic run_burst(input bit bp, input int max_cycles);
        int prev_pend;
        int prev_d;
        int prev_l;
        int finished;
        prev_pend = 0;
        prev_d    = 0;
        prev_l    = 0;
        finished  = 0;
        done_seen = 0;
        got_data.delete();
        got_last.delete();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        set_cfg(8'h00, 7, 1, 9, 0);
        for (int i = 0; i < max_cycles; i++) begin
            m_axis_tready = bp ? ($urandom_range(0, 99) >= 30) : 1'b1;
            if (prev_pend != 0) begin
                chk("hold_valid", int'(m_axis_tvalid), 1);
                chk("hold_data", int'($signed(m_axis_tdata)), prev_d);
                chk("hold_last", int'(m_axis_tlast), prev_l);
            end
            if (status_done) done_seen++;
            if (!status_busy) begin
                finished = 1;
                break;
            end
            if (m_axis_tvalid && m_axis_tready) begin
                got_data.push_back(int'($signed(m_axis_tdata)));
                got_last.push_back(int'(m_axis_tlast));
            end
            prev_pend = (m_axis_tvalid && !m_axis_tready) ? 1 : 0;
            prev_d    = int'($signed(m_axis_tdata));
            prev_l    = int'(m_axis_tlast);
            start     = (i == 5);
            @(negedge clk);
        end
        start = 1'b0;
        m_axis_tready = 1'b1;
        chk("burst_finished", finished, 1);
    endtask

    task automatic compare_stream(input string tag);
        chk({tag, "_len"}, got_data.size(), exp_data.size());
        for (int i = 0; i < got_data.size() && i < exp_data.size(); i++) begin
            chk({tag, "_data"}, got_data[i], exp_data[i]);
            chk({tag, "_last"}, got_last[i], exp_last[i]);
        end
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_tvalid", int'(m_axis_tvalid), 0);
        chk("rst_tdata", int'(m_axis_tdata), 0);
        chk("rst_tlast", int'(m_axis_tlast), 0);
        chk("rst_busy", int'(status_busy), 0);
        chk("rst_done", int'(status_done), 0);
        chk("rst_cnt", int'(status_pulse_cnt), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic pulse (+1,-1,0,+1), start raised together with abort: start wins
        set_cfg(8'b01_11_00_01, 100, 1, 1, 0);
        abort = 1'b1;
        run_burst(1'b0, 60);
        chk("t1_len", got_data.size(), 4);
        if (got_data.size() == 4) begin
            chk("t1_b0", got_data[0], 100);
            chk("t1_b1", got_data[1], -100);
            chk("t1_b2", got_data[2], 0);
            chk("t1_b3", got_data[3], 100);
            chk("t1_last2", got_last[2], 0);
            chk("t1_last3", got_last[3], 1);
        end
        chk("t1_done", done_seen, 1);
        chk("t1_cnt", int'(status_pulse_cnt), 1);

        // Oversampling, two pulses, two gap samples
        set_cfg(8'b01_11_00_01, 100, 3, 2, 2);
        build_exp(8'b01_11_00_01, 100, 3, 2, 2);
        run_burst(1'b0, 100);
        compare_stream("t2");
        if (got_last.size() == 26) begin
            chk("t2_tlast12", got_last[11], 1);
            chk("t2_tlast26", got_last[25], 1);
            chk("t2_gap", got_data[12], 0);
        end
        chk("t2_cnt", int'(status_pulse_cnt), 2);
        chk("t2_done", done_seen, 1);

        // Saturating negate and reserved code, osr=0 treated as 1
        set_cfg(8'b11_10_01_00, -32768, 0, 1, 0);
        run_burst(1'b0, 60);
        chk("t3_len", got_data.size(), 4);
        if (got_data.size() == 4) begin
            chk("t3_neg_sat", got_data[0], 32767);
            chk("t3_rsvd", got_data[1], 0);
            chk("t3_pos_min", got_data[2], -32768);
            chk("t3_zero", got_data[3], 0);
        end

        // Random backpressure reproduces the unthrottled stream
        set_cfg(8'b01_11_00_01, 100, 3, 2, 2);
        build_exp(8'b01_11_00_01, 100, 3, 2, 2);
        run_burst(1'b1, 400);
        compare_stream("t4");
        chk("t4_cnt", int'(status_pulse_cnt), 2);

        // Zero pulses: straight to DONE with no samples
        set_cfg(8'b01_11_00_01, 100, 1, 0, 0);
        run_burst(1'b0, 20);
        chk("t5_len", got_data.size(), 0);
        chk("t5_done", done_seen, 1);
        chk("t5_cnt", int'(status_pulse_cnt), 0);

        // Abort with a pending beat held for three cycles
        set_cfg(8'b01_11_00_01, 100, 3, 2, 2);
        m_axis_tready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        chk("ab_beat5", int'($signed(m_axis_tdata)), -100);
        m_axis_tready = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("ab_hold_valid", int'(m_axis_tvalid), 1);
            chk("ab_hold_data", int'($signed(m_axis_tdata)), -100);
            chk("ab_no_done", int'(status_done), 0);
            @(negedge clk);
        end
        m_axis_tready = 1'b1;
        chk("ab_pend_valid", int'(m_axis_tvalid), 1);
        chk("ab_pend_data", int'($signed(m_axis_tdata)), -100);
        @(negedge clk);
        chk("ab_valid_off", int'(m_axis_tvalid), 0);
        chk("ab_idle", int'(status_busy), 0);
        chk("ab_no_done2", int'(status_done), 0);
        @(negedge clk);
        chk("ab_stays_off", int'(m_axis_tvalid), 0);
        chk("ab_cnt", int'(status_pulse_cnt), 0);

        // Reset mid-burst drops tvalid without a clock edge
        set_cfg(8'b01_11_00_01, 100, 1, 1, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("mr_valid_before", int'(m_axis_tvalid), 1);
        rst_n = 1'b0;
        #1;
        chk("mr_valid", int'(m_axis_tvalid), 0);
        chk("mr_busy", int'(status_busy), 0);
        chk("mr_cnt", int'(status_pulse_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
